// File: rtl/calculator_display.sv
// Signed 16-bit result to 8-digit multiplexed 7-segment display.
// Iterative double-dabble BCD conversion, leading-zero blanking, sign and "Err" handling.
module calculator_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        err_in,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t      r_state, w_next;
  logic        w_busy, w_done;
  logic [3:0]  r_cnt;
  logic [15:0] r_mag;
  logic [19:0] r_bcd, w_adj;
  logic        r_sign_l, r_err_l;
  logic [19:0] r_disp;
  logic        r_sign, r_err;
  logic [CW-1:0] r_refresh;
  logic [2:0]  r_idx;
  logic [6:0]  r_seg_n, w_seg;
  logic [7:0]  r_an_n;
  logic [4:1]  w_blank;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:   if (load) w_next = S_CONV;
      S_CONV: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd15) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < 5; i++)
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_sign_l <= 1'b0;
      r_err_l  <= 1'b0;
      r_disp   <= '0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_err_l  <= err_in;
          r_sign_l <= value_in[15];
          // -32768 negates to 16'h8000, which is 32768 read as unsigned
          r_mag    <= value_in[15] ? 16'(~value_in + 16'd1) : value_in;
          r_bcd    <= '0;
          r_cnt    <= '0;
        end
        S_CONV: begin
          r_bcd <= {w_adj[18:0], r_mag[15]};
          r_mag <= {r_mag[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        S_COMMIT: begin
          r_disp <= r_bcd;
          r_sign <= r_sign_l;
          r_err  <= r_err_l;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  always_comb begin
    w_blank[4] = (r_disp[19:16] == 4'd0);
    w_blank[3] = w_blank[4] && (r_disp[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_disp[11:8]  == 4'd0);
    w_blank[1] = w_blank[2] && (r_disp[7:4]   == 4'd0);
  end

  always_comb begin
    w_seg = 7'h7F;
    if (r_err) begin
      case (r_idx)
        3'd2:       w_seg = 7'h06;
        3'd1, 3'd0: w_seg = 7'h2F;
        default:    w_seg = 7'h7F;
      endcase
    end else begin
      case (r_idx)
        3'd0:    w_seg = enc(r_disp[3:0]);
        3'd1:    w_seg = w_blank[1] ? 7'h7F : enc(r_disp[7:4]);
        3'd2:    w_seg = w_blank[2] ? 7'h7F : enc(r_disp[11:8]);
        3'd3:    w_seg = w_blank[3] ? 7'h7F : enc(r_disp[15:12]);
        3'd4:    w_seg = w_blank[4] ? 7'h7F : enc(r_disp[19:16]);
        3'd5:    w_seg = r_sign ? 7'h3F : 7'h7F;
        default: w_seg = 7'h7F;
      endcase
    end
  end

  // Segment and anode registers share one edge so a digit never shows a neighbour's pattern
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_n <= 7'h7F;
      r_an_n  <= 8'hFF;
    end else begin
      r_seg_n <= w_seg;
      r_an_n  <= ~(8'd1 << r_idx);
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;
  assign dp_n  = 1'b1;

endmodule

// File: tb/tb_calculator_display.sv
// Directed bench for calculator_display with REFRESH_DIV=4.
module tb_calculator_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic        err_in = 1'b0;
  logic        busy, done, dp_n;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  calculator_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .err_in(err_in),
    .busy(busy), .done(done), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int idx, input logic [7:0] exp, input string tag);
    logic [7:0] want;
    int k;
    want = ~(8'd1 << idx);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (an_n !== want && k < 40);
    check({tag, "_an"}, an_n, want);
    check({tag, "_seg"}, {1'b0, seg_n}, exp);
  endtask

  // exp packs digits 5..0, one byte each, digit 5 in the top byte
  task automatic check_display(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++)
      wait_digit(i, exp[8*i +: 8], $sformatf("%s_d%0d", tag, i));
  endtask

  task automatic load_and_check(input logic [15:0] v, input logic e, input string tag);
    @(negedge clk);
    load = 1'b1;
    value_in = v;
    err_in = e;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
      check($sformatf("%s_busy%0d", tag, i), {7'b0, busy}, 8'd1);
      check($sformatf("%s_done%0d", tag, i), {7'b0, done}, (i == 17) ? 8'd1 : 8'd0);
    end
    @(negedge clk);
    check({tag, "_busy_end"}, {7'b0, busy}, 8'd0);
    check({tag, "_done_end"}, {7'b0, done}, 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_done", {7'b0, done}, 8'd0);
    check("rst_seg", {1'b0, seg_n}, 8'h7F);
    check("rst_an", an_n, 8'hFF);
    check("rst_dp", {7'b0, dp_n}, 8'd1);

    reset = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check($sformatf("scan_an%0d", c), an_n, ~(8'd1 << (c / 4)));
      check($sformatf("scan_seg%0d", c), {1'b0, seg_n}, (c / 4 == 0) ? 8'h40 : 8'h7F);
    end

    load_and_check(16'd1234, 1'b0, "v1234");
    @(negedge clk);
    check_display("v1234", 48'h7F7F_7924_3019);

    load_and_check(16'h8000, 1'b0, "vneg32768");
    @(negedge clk);
    check_display("vneg32768", 48'h3F30_2478_0200);

    load_and_check(16'd100, 1'b0, "v100");
    @(negedge clk);
    check_display("v100", 48'h7F7F_7F79_4040);

    load_and_check(16'hFFFB, 1'b0, "vneg5");
    @(negedge clk);
    check_display("vneg5", 48'h3F7F_7F7F_7F12);

    load_and_check(16'd5, 1'b1, "err");
    @(negedge clk);
    check_display("err", 48'h7F7F_7F06_2F2F);

    // second load arrives mid-conversion and must be dropped
    @(negedge clk);
    load = 1'b1;
    value_in = 16'd7;
    err_in = 1'b0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1;
    value_in = 16'd99;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (done) n_done++;
    end
    check("ignore_done_cnt", 8'(n_done), 8'd1);
    check_display("ignore", 48'h7F7F_7F7F_7F78);

    @(negedge clk);
    load = 1'b1;
    value_in = 16'd500;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
    end
    check("midrst_busy_before", {7'b0, busy}, 8'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", {7'b0, busy}, 8'd0);
    check("midrst_done", {7'b0, done}, 8'd0);
    check("midrst_an", an_n, 8'hFF);
    check("midrst_seg", {1'b0, seg_n}, 8'h7F);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_done_cnt", 8'(n_done), 8'd0);
    check("midrst_busy_after", {7'b0, busy}, 8'd0);
    check_display("midrst", 48'h7F7F_7F7F_7F40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
